// File: rtl/pipeline_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer, registered in_ready, and synchronous flush.
// 1-cycle latency; in_ready drops only when the skid entry is occupied. Optional counters under PIPE_STAGE_STATS_EN.
module pipeline_stage_skid #(
  parameter int DATA_W     = 64,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  squash_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Payload registers only take a reset when they are meant to be cleared.
  generate
    if (CLEAR_DATA) begin : g_data_rst
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          main_q <= '0;
          skid_q <= '0;
        end else begin
          main_q <= main_d;
          skid_q <= skid_d;
        end
      end
    end else begin : g_data_nrst
      always_ff @(posedge CLK) begin
        main_q <= main_d;
        skid_q <= skid_d;
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_valid && out_ready) begin
            main_d = in_data;
          end else if (out_ready) begin
            state_d = EMPTY;
          end else if (in_valid) begin
            state_d = TWO;
            skid_d  = in_data;
          end
        end
        TWO: begin
          if (out_ready) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Both handshake outputs decode straight from the state flops, so no input-to-ready path exists.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != TWO);
    out_data  = main_q;
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] squash_q, squash_d;
  logic [1:0]       n_held;
  logic [CNT_W:0]   squash_sum;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q  <= '0;
      squash_q <= '0;
    end else begin
      stall_q  <= stall_d;
      squash_q <= squash_d;
    end
  end

  always_comb begin
    n_held     = (state_q == TWO) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);
    squash_sum = {1'b0, squash_q} + {{(CNT_W-1){1'b0}}, n_held};
    stall_d    = stall_q;
    squash_d   = squash_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (flush)
      squash_d = squash_sum[CNT_W] ? {CNT_W{1'b1}} : squash_sum[CNT_W-1:0];
  end

  assign stall_cnt  = stall_q;
  assign squash_cnt = squash_q;
`endif

endmodule
